// File: rtl/rs_encode_pkg.sv
// Shared GF(2^8) constants, state encoding and generator-polynomial helpers
// for the systematic Reed-Solomon encoder.
package rs_encode_pkg;

  localparam int unsigned RS_SYM_W     = 8;
  localparam logic [8:0]  RS_PRIM_POLY = 9'h11D;
  localparam int unsigned RS_MAX_COEF  = 256;

  typedef logic [RS_MAX_COEF-1:0][RS_SYM_W-1:0] rs_gen_tab_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } rs_enc_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ RS_PRIM_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return r;
  endfunction

  // g(x) = prod (x - alpha^j), j = 0..npar-1; entry i is the x^i coefficient.
  function automatic rs_gen_tab_t rs_gen_coef(input int unsigned npar);
    rs_gen_tab_t g;
    logic [7:0]  root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int unsigned j = 0; j < npar; j++) begin
      for (int unsigned i = j + 1; i > 0; i--) begin
        g[8'(i)] = g[8'(i - 1)] ^ gf_mul(g[8'(i)], root);
      end
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g;
  endfunction

  localparam rs_gen_tab_t RS_GEN_COEF = rs_gen_coef(16);

endpackage

// File: rtl/rs_encode_core_if.sv
// Input/output symbol streams of the RS encoder (valid/ready handshakes).
interface rs_encode_core_if;
  import rs_encode_pkg::*;

  logic                in_valid_i;
  logic                in_ready_o;
  logic [RS_SYM_W-1:0] in_sym_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [RS_SYM_W-1:0] out_sym_o;
  logic                out_last_o;

  modport master (
    output in_valid_i, in_sym_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_sym_o, out_last_o
  );

  modport slave (
    input  in_valid_i, in_sym_i, out_ready_i,
    output in_ready_o, out_valid_o, out_sym_o, out_last_o
  );
endinterface

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier, reduction polynomial 0x11D.
module gf256_mul
  import rs_encode_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  assign p = gf_mul(a, b);
endmodule

// File: rtl/rs_encode_core.sv
// Systematic RS(K+NPAR,K) encoder over GF(2^8): data pass-through then parity.
// Optional output error injection enabled by defining RS_ENCODE_ERR_INJ_EN.
module rs_encode_core
  import rs_encode_pkg::*;
#(
  parameter int unsigned SYM_W = 8,
  parameter int unsigned K     = 184,
  parameter int unsigned NPAR  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  rs_encode_core_if.slave       strm,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  err_inj_en_i,
  input  logic [7:0]            err_inj_pos_i,
  input  logic [7:0]            err_inj_mask_i
);

  localparam int unsigned N     = K + NPAR;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] LAST_SYM  = CNT_W'(N - 1);
  localparam rs_gen_tab_t GEN = (NPAR == 16) ? RS_GEN_COEF : rs_gen_coef(NPAR);

  rs_enc_state_e                  state;
  logic [NPAR-1:0][SYM_W-1:0]     par;
  logic [NPAR-1:0][SYM_W-1:0]     par_fb;
  logic [NPAR-1:0][SYM_W-1:0]     prod;
  logic [CNT_W-1:0]               sym_cnt;
  logic [SYM_W-1:0]               fb;
  logic [SYM_W-1:0]               sym;
  logic                           hs;

  assign fb = strm.in_sym_i ^ par[NPAR-1];

  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    gf256_mul u_mul (
      .a (fb),
      .b (GEN[i]),
      .p (prod[i])
    );
    if (i == 0) begin : g_first
      assign par_fb[i] = prod[i];
    end else begin : g_rest
      assign par_fb[i] = par[i-1] ^ prod[i];
    end
  end

  always_comb begin
    strm.in_ready_o  = 1'b0;
    strm.out_valid_o = 1'b0;
    strm.out_last_o  = 1'b0;
    sym              = '0;
    hs               = 1'b0;
    unique case (state)
      DATA: begin
        strm.in_ready_o  = strm.out_ready_i;
        strm.out_valid_o = strm.in_valid_i;
        sym              = strm.in_sym_i;
        hs               = strm.in_valid_i && strm.out_ready_i;
      end
      PARITY: begin
        strm.out_valid_o = 1'b1;
        sym              = par[NPAR-1];
        strm.out_last_o  = (sym_cnt == LAST_SYM);
        hs               = strm.out_ready_i;
      end
      default: ;
    endcase
`ifdef RS_ENCODE_ERR_INJ_EN
    // Corrupts only the emitted symbol; the LFSR still sees the clean input.
    if (state != IDLE && err_inj_en_i && 16'(sym_cnt) == 16'(err_inj_pos_i))
      sym = sym ^ err_inj_mask_i;
`endif
    strm.out_sym_o = sym;
  end

`ifndef RS_ENCODE_ERR_INJ_EN
  logic unused_err_inj;
  assign unused_err_inj = ^{err_inj_en_i, err_inj_pos_i, err_inj_mask_i};
`endif

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state   <= IDLE;
      par     <= '0;
      sym_cnt <= '0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: state <= DATA;
        DATA: begin
          if (hs) begin
            par     <= par_fb;
            sym_cnt <= sym_cnt + CNT_W'(1);
            if (sym_cnt == LAST_DATA) state <= PARITY;
          end
        end
        PARITY: begin
          if (hs) begin
            par <= {par[NPAR-2:0], {SYM_W{1'b0}}};
            if (sym_cnt == LAST_SYM) begin
              state   <= IDLE;
              sym_cnt <= '0;
              done_o  <= 1'b1;
            end else begin
              sym_cnt <= sym_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encode_core.sv
// Randomized self-checking bench for rs_encode_core against a polynomial-division RS model.
module tb_rs_encode_core;

  localparam int K    = 184;
  localparam int NPAR = 16;
  localparam int N    = K + NPAR;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       busy;
  logic       done;
  logic       inj_en;
  logic [7:0] inj_pos;
  logic [7:0] inj_mask;

  rs_encode_core_if strm ();

  rs_encode_core #(.SYM_W(8), .K(K), .NPAR(NPAR)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clr_i          (clr),
    .strm           (strm),
    .busy_o         (busy),
    .done_o         (done),
    .err_inj_en_i   (inj_en),
    .err_inj_pos_i  (inj_pos),
    .err_inj_mask_i (inj_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int done_cnt;
  int exp_t [256];
  int log_t [256];
  int tgen  [NPAR+1];
  int din   [N];
  int expv  [N];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic build_tables();
    int nxt [NPAR+1];
    exp_t[0] = 1;
    for (int i = 1; i < 255; i++) begin
      int v;
      v = exp_t[i-1] * 2;
      if (v >= 256) v = v ^ 'h11D;
      exp_t[i] = v;
    end
    for (int i = 0; i < 255; i++) log_t[exp_t[i]] = i;
    for (int i = 0; i <= NPAR; i++) tgen[i] = 0;
    tgen[0] = 1;
    for (int j = 0; j < NPAR; j++) begin
      nxt[0] = gmul(tgen[0], exp_t[j]);
      for (int i = 1; i <= NPAR; i++) nxt[i] = tgen[i-1] ^ gmul(tgen[i], exp_t[j]);
      tgen = nxt;
    end
  endtask

  // Parity = remainder of d(x)*x^NPAR divided by g(x), via synthetic division.
  task automatic build_exp();
    int msg [N];
    for (int i = 0; i < N; i++) msg[i] = (i < K) ? din[i] : 0;
    for (int i = 0; i < K; i++) begin
      int c;
      c = msg[i];
      if (c != 0)
        for (int j = 1; j <= NPAR; j++) msg[i+j] = msg[i+j] ^ gmul(tgen[NPAR-j], c);
    end
    for (int i = 0; i < N; i++) expv[i] = (i < K) ? din[i] : msg[i];
  endtask

  task automatic rand_data();
    for (int i = 0; i < K; i++) din[i] = int'($urandom_range(255));
  endtask

  // abort_kind: 0 none, 1 clr, 2 rst; applied when stop_at symbols have been emitted.
  task automatic run_frame(input int ready_pct, input int stop_at, input int abort_kind);
    int idx = 0;
    int cyc = 0;
    while (idx < N && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (abort_kind != 0 && idx == stop_at) begin
        if (abort_kind == 1) clr = 1'b1; else rst = 1'b1;
        strm.in_valid_i  = 1'b1;
        strm.out_ready_i = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        rst = 1'b0;
        chk("abort_busy",   32'(busy),             0);
        chk("abort_ovalid", 32'(strm.out_valid_o), 0);
        chk("abort_irdy",   32'(strm.in_ready_o),  0);
        chk("abort_last",   32'(strm.out_last_o),  0);
        chk("abort_sym",    32'(strm.out_sym_o),   0);
        chk("abort_done",   32'(done),             0);
        return;
      end
      strm.in_valid_i  = (idx < K);
      strm.in_sym_i    = (idx < K) ? 8'(din[idx]) : 8'($urandom);
      strm.out_ready_i = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (busy) begin
        if (idx < K) chk("rdy_follow", 32'(strm.in_ready_o), 32'(strm.out_ready_i));
        else begin
          chk("par_irdy",   32'(strm.in_ready_o),  0);
          chk("par_ovalid", 32'(strm.out_valid_o), 1);
        end
      end
      if (strm.out_valid_o && strm.out_ready_i) begin
        chk($sformatf("sym[%0d]", idx), 32'(strm.out_sym_o), 32'(expv[idx]));
        chk($sformatf("last[%0d]", idx), 32'(strm.out_last_o), 32'(idx == N - 1));
        idx++;
      end
    end
    chk("sym_count", 32'(idx), 32'(N));
    strm.in_valid_i  = 1'b0;
    strm.out_ready_i = 1'b1;
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy",  32'(busy), 0);
    chk("done_irdy",  32'(strm.in_ready_o), 0);
    @(negedge clk);
    chk("done_once",  32'(done), 0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    done_cnt = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    inj_en   = 1'b0;
    inj_pos  = 8'd5;
    inj_mask = 8'hFF;
    strm.in_valid_i  = 1'b1;
    strm.in_sym_i    = 8'h3C;
    strm.out_ready_i = 1'b1;
    build_tables();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy),             0);
    chk("rst_done",   32'(done),             0);
    chk("rst_ovalid", 32'(strm.out_valid_o), 0);
    chk("rst_irdy",   32'(strm.in_ready_o),  0);
    chk("rst_last",   32'(strm.out_last_o),  0);
    chk("rst_sym",    32'(strm.out_sym_o),   0);
    rst = 1'b0;
    chk("idle_bubble_irdy", 32'(strm.in_ready_o), 0);

    // All-zero data: codeword is all zero.
    for (int i = 0; i < K; i++) din[i] = 0;
    build_exp();
    run_frame(100, N, 0);

    // Single 1 in the lowest data position: parity is the generator tail.
    for (int i = 0; i < K; i++) din[i] = 0;
    din[K-1] = 1;
    for (int i = 0; i < N; i++) expv[i] = (i < K) ? din[i] : tgen[N - 1 - i];
    run_frame(100, N, 0);

    // Random data under 50% backpressure, injection disabled but ports busy.
    for (int f = 0; f < 3; f++) begin
      inj_pos  = 8'($urandom_range(N - 1));
      inj_mask = 8'($urandom_range(1, 255));
      rand_data();
      build_exp();
      run_frame(50, N, 0);
    end

    // Abort by clr in DATA, then a clean frame.
    rand_data();
    build_exp();
    run_frame(70, 100, 1);
    rand_data();
    build_exp();
    run_frame(60, N, 0);

    // Reset in PARITY, then a clean frame.
    rand_data();
    build_exp();
    run_frame(80, 190, 2);
    rand_data();
    build_exp();
    run_frame(50, N, 0);

    // Error injection on data symbol 5.
    rand_data();
    din[5] = 'hA5;
    build_exp();
`ifdef RS_ENCODE_ERR_INJ_EN
    expv[5] = expv[5] ^ 'hFF;
`endif
    inj_en   = 1'b1;
    inj_pos  = 8'd5;
    inj_mask = 8'hFF;
    run_frame(50, N, 0);
    inj_en = 1'b0;

    repeat (2) @(negedge clk);
    chk("done_total", 32'(done_cnt), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
